vid_timing_gen: RTL and testbench

- Raster timing generator in the `hdmi_tx_clk148m5` domain.
- Produces the `{D_sync, Vsync, Hsync}` and `{Vblank, Hblank}` timing buses that drive the video unit under test, plus pixel coordinates and frame/line markers.
- Default parameters give 1920x1080p60 (2200x1125 total at 148.5 MHz, one pixel per `cen_i`).
- Sits directly upstream of `video_uut`.
- Supports a clean start/stop handshake so the downstream pipeline only ever sees whole frames.

---
 rtl/vid_timing_gen.sv | 143 ++++++++++++++
 tb/tb_vid_timing_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vid_timing_gen.sv
// Raster timing generator: sync/blank buses, pixel position and
// frame/line markers, with a whole-frame start/stop handshake.
module vid_timing_gen #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter bit H_POL    = 1'b1,
   parameter bit V_POL    = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        cen_i,
   input  logic        en_i,
   output logic [2:0]  dvh_sync_o,
   output logic [1:0]  vh_blank_o,
   output logic [11:0] pix_x_o,
   output logic [10:0] pix_y_o,
   output logic        sol_o,
   output logic        sof_o,
   output logic        busy_o,
   output logic [15:0] frame_cnt_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 4096) begin : g_h_err
      $error("vid_timing_gen: H_TOTAL exceeds 4096");
   end
   if (V_TOTAL > 2048) begin : g_v_err
      $error("vid_timing_gen: V_TOTAL exceeds 2048");
   end

   localparam logic [11:0] HA    = 12'(H_ACTIVE);
   localparam logic [11:0] HS0   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS1   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] HT_M1 = 12'(H_TOTAL - 1);
   localparam logic [10:0] VA    = 11'(V_ACTIVE);
   localparam logic [10:0] VS0   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS1   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] VT_M1 = 11'(V_TOTAL - 1);

   // Blanked bus values shown while idle or in reset
   localparam logic [2:0] IDLE_DVH = {1'b0, ~V_POL, ~H_POL};
   localparam logic [1:0] IDLE_VHB = 2'b11;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t      state;
   logic        eol;
   logic        last;
   logic [11:0] nx;
   logic [10:0] ny;

   // Sync/blank bits for a position: {D, V, H, Vblank, Hblank}
   function automatic logic [4:0] decode(
      input logic [11:0] x,
      input logic [10:0] y
   );
      logic hb, vb, ha, va;
      hb = (x >= HA);
      vb = (y >= VA);
      ha = (x >= HS0) && (x < HS1);
      va = (y >= VS0) && (y < VS1);
      return {~hb & ~vb,
              va ? V_POL : ~V_POL,
              ha ? H_POL : ~H_POL,
              vb, hb};
   endfunction

   // Next raster position and end-of-line / end-of-frame flags
   always_comb begin
      eol  = (pix_x_o == HT_M1);
      last = eol && (pix_y_o == VT_M1);
      nx   = eol ? 12'd0 : pix_x_o + 12'd1;
      ny   = pix_y_o;
      if (eol) begin
         ny = (pix_y_o == VT_M1) ? 11'd0 : pix_y_o + 11'd1;
      end
   end

   // IDLE/RUN sequencer with all outputs registered from the next position
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= IDLE;
         dvh_sync_o  <= IDLE_DVH;
         vh_blank_o  <= IDLE_VHB;
         pix_x_o     <= '0;
         pix_y_o     <= '0;
         sol_o       <= 1'b0;
         sof_o       <= 1'b0;
         busy_o      <= 1'b0;
         frame_cnt_o <= '0;
      end else begin
         sol_o <= 1'b0;
         sof_o <= 1'b0;
         if (cen_i) begin
            unique case (state)
               IDLE: begin
                  if (en_i) begin
                     state       <= RUN;
                     busy_o      <= 1'b1;
                     pix_x_o     <= '0;
                     pix_y_o     <= '0;
                     {dvh_sync_o, vh_blank_o} <= decode(12'd0, 11'd0);
                     sol_o       <= 1'b1;
                     sof_o       <= 1'b1;
                     frame_cnt_o <= frame_cnt_o + 16'd1;
                  end
               end
               RUN: begin
                  if (last && !en_i) begin
                     state      <= IDLE;
                     busy_o     <= 1'b0;
                     pix_x_o    <= '0;
                     pix_y_o    <= '0;
                     dvh_sync_o <= IDLE_DVH;
                     vh_blank_o <= IDLE_VHB;
                  end else begin
                     pix_x_o <= nx;
                     pix_y_o <= ny;
                     {dvh_sync_o, vh_blank_o} <= decode(nx, ny);
                     sol_o   <= eol;
                     sof_o   <= last;
                     if (last) begin
                        frame_cnt_o <= frame_cnt_o + 16'd1;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Directed bench for vid_timing_gen using a 14x7 raster.
module tb_vid_timing_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cen;
   logic        en;
   logic [2:0]  dvh;
   logic [1:0]  vhb;
   logic [11:0] px;
   logic [10:0] py;
   logic        sol;
   logic        sof;
   logic        busy;
   logic [15:0] fcnt;

   int checks = 0;
   int errors = 0;
   int cur = 0;

   vid_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b1)
   ) dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .cen_i(cen),
      .en_i(en),
      .dvh_sync_o(dvh),
      .vh_blank_o(vhb),
      .pix_x_o(px),
      .pix_y_o(py),
      .sol_o(sol),
      .sof_o(sof),
      .busy_o(busy),
      .frame_cnt_o(fcnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          k;
      logic [11:0] x;
      logic [10:0] y;
      logic [2:0]  dvh;
      logic [1:0]  vhb;
      logic        sol;
      logic        sof;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic restart();
      rst_n = 1'b0;
      cen   = 1'b1;
      en    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      @(negedge clk);
      cur = 0;
   endtask

   task automatic adv(input int k);
      while (cur < k) begin
         @(negedge clk);
         cur++;
      end
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, " dvh"}, 32'(dvh), 32'h0);
      chk({nm, " vhb"}, 32'(vhb), 32'h3);
      chk({nm, " x"}, 32'(px), 0);
      chk({nm, " y"}, 32'(py), 0);
      chk({nm, " busy"}, 32'(busy), 0);
      chk({nm, " sof"}, 32'(sof), 0);
      chk({nm, " sol"}, 32'(sol), 0);
   endtask

   initial begin
      int first;
      int second;
      int sofs;

      tbl[0]  = '{0,  0, 0, 3'b100, 2'b00, 1, 1, 1};
      tbl[1]  = '{1,  1, 0, 3'b100, 2'b00, 0, 0, 1};
      tbl[2]  = '{7,  7, 0, 3'b100, 2'b00, 0, 0, 1};
      tbl[3]  = '{8,  8, 0, 3'b000, 2'b01, 0, 0, 1};
      tbl[4]  = '{10, 10, 0, 3'b001, 2'b01, 0, 0, 1};
      tbl[5]  = '{11, 11, 0, 3'b001, 2'b01, 0, 0, 1};
      tbl[6]  = '{12, 12, 0, 3'b000, 2'b01, 0, 0, 1};
      tbl[7]  = '{14, 0, 1, 3'b100, 2'b00, 1, 0, 1};
      tbl[8]  = '{56, 0, 4, 3'b000, 2'b10, 1, 0, 1};
      tbl[9]  = '{70, 0, 5, 3'b010, 2'b10, 1, 0, 1};
      tbl[10] = '{80, 10, 5, 3'b011, 2'b11, 0, 0, 1};
      tbl[11] = '{84, 0, 6, 3'b000, 2'b10, 1, 0, 1};
      tbl[12] = '{97, 13, 6, 3'b000, 2'b11, 0, 0, 1};
      tbl[13] = '{98, 0, 0, 3'b100, 2'b00, 1, 1, 2};
      tbl[14] = '{99, 1, 0, 3'b100, 2'b00, 0, 0, 2};

      // reset values
      rst_n = 1'b0;
      cen   = 1'b1;
      en    = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle("reset");
      chk("reset cnt", 32'(fcnt), 0);

      // start and free-running raster
      restart();
      foreach (tbl[i]) begin
         adv(tbl[i].k);
         chk($sformatf("k%0d x", tbl[i].k), 32'(px), 32'(tbl[i].x));
         chk($sformatf("k%0d y", tbl[i].k), 32'(py), 32'(tbl[i].y));
         chk($sformatf("k%0d dvh", tbl[i].k), 32'(dvh), 32'(tbl[i].dvh));
         chk($sformatf("k%0d vhb", tbl[i].k), 32'(vhb), 32'(tbl[i].vhb));
         chk($sformatf("k%0d sol", tbl[i].k), 32'(sol), 32'(tbl[i].sol));
         chk($sformatf("k%0d sof", tbl[i].k), 32'(sof), 32'(tbl[i].sof));
         chk($sformatf("k%0d cnt", tbl[i].k), 32'(fcnt), 32'(tbl[i].cnt));
         chk($sformatf("k%0d busy", tbl[i].k), 32'(busy), 1);
      end

      // clock enable toggling
      rst_n = 1'b0;
      cen   = 1'b1;
      en    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      en     = 1'b1;
      first  = -1;
      second = -1;
      sofs   = 0;
      for (int n = 0; n < 206; n++) begin
         if (n > 0) begin
            if (sof) begin
               sofs++;
               if (first < 0) first = n;
               else if (second < 0) second = n;
            end
            if (n == 1) chk("cen sof n1", 32'(sof), 1);
            if (n == 2) chk("cen sof n2", 32'(sof), 0);
            if (n == 2) chk("cen x n2", 32'(px), 0);
            if (n == 3) chk("cen x n3", 32'(px), 1);
            if (n == 4) chk("cen x n4", 32'(px), 1);
            if (n == 5) chk("cen x n5", 32'(px), 2);
         end
         cen = (n % 2 == 0);
         @(negedge clk);
      end
      chk("cen sof count", 32'(sofs), 2);
      chk("cen period", 32'(second - first), 196);

      // clean stop
      restart();
      adv(31);
      chk("stop x", 32'(px), 3);
      chk("stop y", 32'(py), 2);
      en = 1'b0;
      adv(97);
      chk("stop last x", 32'(px), 13);
      chk("stop last y", 32'(py), 6);
      chk("stop last busy", 32'(busy), 1);
      adv(98);
      chk_idle("stop idle");
      chk("stop cnt", 32'(fcnt), 1);
      adv(105);
      chk_idle("stop hold");
      chk("stop hold cnt", 32'(fcnt), 1);

      // cancelled stop
      restart();
      adv(31);
      en = 1'b0;
      adv(61);
      chk("cancel x", 32'(px), 5);
      chk("cancel y", 32'(py), 4);
      en = 1'b1;
      adv(97);
      chk("cancel busy", 32'(busy), 1);
      adv(98);
      chk("cancel wrap x", 32'(px), 0);
      chk("cancel wrap y", 32'(py), 0);
      chk("cancel sof", 32'(sof), 1);
      chk("cancel cnt", 32'(fcnt), 2);
      chk("cancel busy2", 32'(busy), 1);

      // asynchronous reset mid-frame
      restart();
      adv(48);
      chk("arst pre x", 32'(px), 6);
      chk("arst pre y", 32'(py), 3);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("arst");
      chk("arst cnt", 32'(fcnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      cen   = 1'b1;
      @(negedge clk);
      chk("arst restart x", 32'(px), 0);
      chk("arst restart y", 32'(py), 0);
      chk("arst restart sof", 32'(sof), 1);
      chk("arst restart cnt", 32'(fcnt), 1);
      chk("arst restart busy", 32'(busy), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
